// File: rtl/ad5628_spi_rx_if.sv
// ad5628_spi_rx_if
//   Three-wire AD5628 serial bus (SYNC/SCLK/DIN).
//   master : drives sclk, cs, mosi (DAC driver or testbench)
//   slave  : samples sclk, cs, mosi (ad5628_spi_rx)
//   sclk : serial clock, bits launched on the rising edge
//   cs   : SYNC, active low
//   mosi : serial data, MSB first
interface ad5628_spi_rx_if;
  logic sclk;
  logic cs;
  logic mosi;

  modport master (output sclk, output cs, output mosi);
  modport slave  (input  sclk, input  cs, input  mosi);
endinterface

// File: rtl/ad5628_spi_rx.sv
// ad5628_spi_rx
//   Device-side responder for the AD5628 octal DAC serial link. Oversamples
//   the bus on clk, deserialises 32-bit frames and maintains the input/DAC
//   registers, internal-reference enable and LDAC mask.
//
//   Build option: define AD5628_SPI_RX_PWRDN_EN to add per-channel power-down
//   (cmd 0x4, pd_mode output). Without it cmd 0x4 is rejected with cmd_err.
//
//   Ports
//     clk         system clock, at least 4x sclk
//     rst         synchronous active-high reset
//     bus         serial bus (slave modport): sclk, cs, mosi
//     dac_out     DAC registers, channel A in the LSBs
//     ref_en      internal reference enable
//     ldac_mask   LDAC register
//     word_out    last executed frame
//     word_valid  1-cycle pulse per executed frame
//     cmd_err     1-cycle pulse on invalid command or address
//     frame_abort 1-cycle pulse when cs rises after 1..31 bits
//     pd_mode     2 bits per channel power-down mode (option only)
//
//   state   | meaning
//   WAIT_HI | ignore the bus until cs is seen high
//   IDLE    | waiting for cs to fall
//   SHIFT   | shifting bits on sclk falling edges
//   EXEC    | one cycle: decode and apply the frame
//   DONE    | frame consumed, ignore sclk until cs rises
module ad5628_spi_rx #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ad5628_spi_rx_if.slave       bus,
  output logic [8*DATA_W-1:0]  dac_out,
  output logic                 ref_en,
  output logic [7:0]           ldac_mask,
  output logic [31:0]          word_out,
  output logic                 word_valid,
  output logic                 cmd_err,
  output logic                 frame_abort
`ifdef AD5628_SPI_RX_PWRDN_EN
  ,
  output logic [15:0]          pd_mode
`endif
);

  typedef enum logic [2:0] {
    WAIT_HI,
    IDLE,
    SHIFT,
    EXEC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic sclk_fall, cs_fall, cs_rise;

  logic [31:0] shreg;
  logic [4:0]  bit_cnt;
  logic        shift_en, cnt_clr, do_abort;

  logic [DATA_W-1:0] in_reg  [8];
  logic [DATA_W-1:0] dac_reg [8];

  logic [3:0]        cmd, addr;
  logic [DATA_W-1:0] code;
  logic [7:0]        sel;
  logic              addr_ok;

  // mosi goes through the same depth as sclk so the bit seen with a
  // detected falling edge is the one the master held across that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_HI;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    do_abort = 1'b0;
    case (state)
      WAIT_HI: if (cs_s) state_nx = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_nx = SHIFT;
          cnt_clr  = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = sclk_fall;
        // 32nd edge wins over a simultaneous cs rise: the frame is complete.
        if (sclk_fall && bit_cnt == 5'd31) begin
          state_nx = EXEC;
        end else if (cs_rise) begin
          state_nx = IDLE;
          do_abort = sclk_fall || (bit_cnt != 5'd0);
        end
      end
      EXEC: state_nx = DONE;
      // Level test so a cs rise landing during EXEC is not lost.
      DONE: if (cs_s) state_nx = IDLE;
      default: state_nx = WAIT_HI;
    endcase
  end

  assign cmd     = shreg[27:24];
  assign addr    = shreg[23:20];
  assign code    = shreg[19 -: DATA_W];
  assign addr_ok = !addr[3] || (addr == 4'hF);

  always_comb begin
    sel = '0;
    if (addr == 4'hF)  sel = 8'hFF;
    else if (!addr[3]) sel[addr[2:0]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      ref_en      <= 1'b0;
      ldac_mask   <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      cmd_err     <= 1'b0;
      frame_abort <= 1'b0;
`ifdef AD5628_SPI_RX_PWRDN_EN
      pd_mode     <= '0;
`endif
      for (int i = 0; i < 8; i++) begin
        in_reg[i]  <= '0;
        dac_reg[i] <= '0;
      end
    end else begin
      word_valid  <= 1'b0;
      cmd_err     <= 1'b0;
      frame_abort <= do_abort;

      if (cnt_clr) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {shreg[30:0], mosi_s};
        bit_cnt <= bit_cnt + 5'd1;
      end

      if (state == EXEC) begin
        word_out   <= shreg;
        word_valid <= 1'b1;
        case (cmd)
          4'h0, 4'h1, 4'h2, 4'h3: begin
            if (!addr_ok) begin
              cmd_err <= 1'b1;
            end else begin
              for (int i = 0; i < 8; i++) begin
                case (cmd)
                  4'h0: begin
                    if (sel[i]) begin
                      in_reg[i] <= code;
                      if (ldac_mask[i]) dac_reg[i] <= code;
                    end
                  end
                  4'h1: if (sel[i]) dac_reg[i] <= in_reg[i];
                  // Update-all must see the value written in this same frame.
                  4'h2: begin
                    if (sel[i]) begin
                      in_reg[i]  <= code;
                      dac_reg[i] <= code;
                    end else begin
                      dac_reg[i] <= in_reg[i];
                    end
                  end
                  default: begin
                    if (sel[i]) begin
                      in_reg[i]  <= code;
                      dac_reg[i] <= code;
                    end
                  end
                endcase
              end
            end
          end
          4'h4: begin
`ifdef AD5628_SPI_RX_PWRDN_EN
            for (int i = 0; i < 8; i++)
              if (shreg[i]) pd_mode[2*i +: 2] <= shreg[9:8];
`else
            cmd_err <= 1'b1;
`endif
          end
          4'h6: ldac_mask <= shreg[7:0];
          4'h7: begin
            ref_en    <= 1'b0;
            ldac_mask <= '0;
`ifdef AD5628_SPI_RX_PWRDN_EN
            pd_mode   <= '0;
`endif
            for (int i = 0; i < 8; i++) begin
              in_reg[i]  <= '0;
              dac_reg[i] <= '0;
            end
          end
          4'h8: ref_en <= shreg[0];
          default: cmd_err <= 1'b1;
        endcase
      end
    end
  end

  // Powered-down channels read 0 but keep their DAC register for power-up.
  for (genvar g = 0; g < 8; g++) begin : g_out
`ifdef AD5628_SPI_RX_PWRDN_EN
    assign dac_out[g*DATA_W +: DATA_W] =
      (pd_mode[2*g +: 2] != 2'b00) ? '0 : dac_reg[g];
`else
    assign dac_out[g*DATA_W +: DATA_W] = dac_reg[g];
`endif
  end

endmodule

// File: tb/tb_ad5628_spi_rx.sv
// tb_ad5628_spi_rx
//   Self-checking bench for ad5628_spi_rx: directed frames followed by
//   random frames, compared against a frame-level model of the DAC.
module tb_ad5628_spi_rx;
  localparam int DW   = 12;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst;
  logic [8*DW-1:0] dac_out;
  logic            ref_en;
  logic [7:0]      ldac_mask;
  logic [31:0]     word_out;
  logic            word_valid, cmd_err, frame_abort;
`ifdef AD5628_SPI_RX_PWRDN_EN
  logic [15:0]     pd_mode;
`endif

  ad5628_spi_rx_if bus_if ();

  ad5628_spi_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .dac_out     (dac_out),
    .ref_en      (ref_en),
    .ldac_mask   (ldac_mask),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .cmd_err     (cmd_err),
    .frame_abort (frame_abort)
`ifdef AD5628_SPI_RX_PWRDN_EN
    ,
    .pd_mode     (pd_mode)
`endif
  );

  always #5 clk = ~clk;

  int n_valid = 0, n_err = 0, n_abort = 0;
  always @(negedge clk) begin
    if (word_valid)  n_valid <= n_valid + 1;
    if (cmd_err)     n_err   <= n_err + 1;
    if (frame_abort) n_abort <= n_abort + 1;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame-level DAC model
  logic [DW-1:0] m_in [8];
  logic [DW-1:0] m_dac[8];
  logic          m_ref;
  logic [7:0]    m_ldac;
  logic [15:0]   m_pd;
  logic [31:0]   m_word;

  task automatic model_reset();
    for (int c = 0; c < 8; c++) begin
      m_in[c]  = '0;
      m_dac[c] = '0;
    end
    m_ref = 1'b0; m_ldac = '0; m_pd = '0; m_word = '0;
  endtask

  task automatic model_exec(input logic [31:0] w, output bit err);
    int cmd, addr;
    logic [DW-1:0] code;
    bit hit[8];
    cmd  = int'(w[27:24]);
    addr = int'(w[23:20]);
    code = w[19 -: DW];
    err  = 0;
    m_word = w;
    for (int c = 0; c < 8; c++) hit[c] = (addr == 15) || (addr == c);
    if (cmd <= 3) begin
      if (addr >= 8 && addr != 15) begin
        err = 1;
      end else begin
        if (cmd != 1)
          for (int c = 0; c < 8; c++) if (hit[c]) m_in[c] = code;
        for (int c = 0; c < 8; c++) begin
          if (cmd == 0 && hit[c] && m_ldac[c]) m_dac[c] = m_in[c];
          if (cmd == 1 && hit[c])              m_dac[c] = m_in[c];
          if (cmd == 2)                        m_dac[c] = m_in[c];
          if (cmd == 3 && hit[c])              m_dac[c] = m_in[c];
        end
      end
    end else if (cmd == 4) begin
`ifdef AD5628_SPI_RX_PWRDN_EN
      for (int c = 0; c < 8; c++) if (w[c]) m_pd[2*c +: 2] = w[9:8];
`else
      err = 1;
`endif
    end else if (cmd == 6) begin
      m_ldac = w[7:0];
    end else if (cmd == 7) begin
      for (int c = 0; c < 8; c++) begin
        m_in[c]  = '0;
        m_dac[c] = '0;
      end
      m_ref = 1'b0; m_ldac = '0; m_pd = '0;
    end else if (cmd == 8) begin
      m_ref = w[0];
    end else begin
      err = 1;
    end
  endtask

  function automatic logic [8*DW-1:0] exp_dac();
    logic [8*DW-1:0] v;
    v = '0;
    for (int c = 0; c < 8; c++)
      if (m_pd[2*c +: 2] == 2'b00) v[c*DW +: DW] = m_dac[c];
    return v;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".dac_out"},   dac_out,   exp_dac());
    check({tag, ".ref_en"},    ref_en,    m_ref);
    check({tag, ".ldac_mask"}, ldac_mask, m_ldac);
    check({tag, ".word_out"},  word_out,  m_word);
`ifdef AD5628_SPI_RX_PWRDN_EN
    check({tag, ".pd_mode"},   pd_mode,   m_pd);
`endif
  endtask

  task automatic clock_bit(input logic b);
    bus_if.sclk = 1'b1;
    bus_if.mosi = b;
    #(HALF);
    bus_if.sclk = 1'b0;
    #(HALF);
  endtask

  task automatic send_frame(input string tag, input logic [31:0] w, input int nbits);
    int v0, e0, a0;
    bit err;
    v0 = n_valid; e0 = n_err; a0 = n_abort;
    bus_if.cs = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++)
      clock_bit(i < 32 ? w[31 - (i % 32)] : 1'($urandom));
    bus_if.cs = 1'b1;
    #(HALF * 3);
    err = 0;
    if (nbits >= 32) model_exec(w, err);
    check({tag, ".word_valid"},  n_valid - v0, (nbits >= 32) ? 1 : 0);
    check({tag, ".cmd_err"},     n_err - e0,   err ? 1 : 0);
    check({tag, ".frame_abort"}, n_abort - a0, (nbits > 0 && nbits < 32) ? 1 : 0);
    check_state(tag);
  endtask

  initial begin
    logic [31:0] w;
    int r, nb, v0, a0;
    logic [3:0] cmd, addr;

    rst = 1'b1;
    bus_if.cs = 1'b1; bus_if.sclk = 1'b0; bus_if.mosi = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #(HALF);
    check("reset.word_valid", word_valid, 1'b0);
    check("reset.cmd_err", cmd_err, 1'b0);
    check("reset.frame_abort", frame_abort, 1'b0);
    check_state("reset");

    send_frame("ref_on",     32'h08000001, 32);
    send_frame("wr_upd_a",   32'h030ABC00, 32);
    send_frame("wr_upd_all", 32'h03F55500, 32);
    send_frame("wr_in_d",    32'h00312300, 32);
    send_frame("upd_d",      32'h01300000, 32);
    send_frame("ldac_d",     32'h06000008, 32);
    send_frame("wr_in_ldac", 32'h00345600, 32);
    send_frame("abort20",    32'h03012300, 20);
    send_frame("after_abrt", 32'h03012300, 32);
    send_frame("edges40",    32'h03265400, 40);
    send_frame("zero_bits",  32'h00000000, 0);
    send_frame("bad_addr",   32'h0390F000, 32);
    send_frame("bad_cmd",    32'h0F000000, 32);
    send_frame("wr_in_upd",  32'h02177700, 32);
`ifdef AD5628_SPI_RX_PWRDN_EN
    send_frame("pd_a",       32'h04000301, 32);
    send_frame("pu_a",       32'h04000001, 32);
`else
    send_frame("pd_cmd",     32'h04000301, 32);
`endif
    send_frame("sw_reset",   32'h07000000, 32);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 19);
      cmd = (r < 16) ? 4'(r) : 4'(r - 16);
      if ($urandom_range(0, 9) < 8) begin
        addr = 4'($urandom_range(0, 8));
        if (addr == 4'd8) addr = 4'hF;
      end else begin
        addr = 4'($urandom);
      end
      w = {4'($urandom), cmd, addr, 20'($urandom)};
      r = $urandom_range(0, 19);
      nb = (r < 17) ? 32 : (r == 17) ? 40 : $urandom_range(0, 31);
      send_frame("rand", w, nb);
    end

    // Reset in the middle of a frame with cs held low throughout.
    v0 = n_valid; a0 = n_abort;
    w = 32'h03F12300;
    bus_if.cs = 1'b0;
    #(HALF);
    for (int i = 0; i < 32; i++) begin
      if (i == 12) rst = 1'b1;
      if (i == 16) rst = 1'b0;
      clock_bit(w[31 - i]);
    end
    bus_if.cs = 1'b1;
    #(HALF * 3);
    model_reset();
    check("rst_mid.word_valid", n_valid - v0, 0);
    check("rst_mid.frame_abort", n_abort - a0, 0);
    check_state("rst_mid");
    send_frame("post_rst", 32'h03F12300, 32);
    send_frame("post_rst_ref", 32'h08000001, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
